bus_master_if: RTL and testbench

CPU-side initiator for the system data bus. It converts a single MEM-stage load/store request into one bus transfer that peripheral responders (segment display, switches, RAM) complete by raising ack. It holds the pipeline in stall until the responder acks or a timeout expires, then returns read data. It sits between the MEM stage and the bus address decoder/arbiter.

---
 rtl/bus_master_if_pkg.sv | 26 ++
 rtl/bus_master_if_timeout_counter.sv | 40 ++++
 rtl/bus_master_if.sv | 125 ++++++++++++
 tb/tb_bus_master_if.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the CPU-side bus initiator: FSM encoding, bus widths,
// the default read data returned on timeout, and the counter width helper.
package bus_master_if_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;

    localparam logic [WB_DATA_W-1:0] BM_ERR_DATA_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BM_IDLE = 2'd0,
        BM_BUSY = 2'd1,
        BM_DONE = 2'd2
    } bm_state_e;

    // Width of a counter able to hold 0..timeout-1, never narrower than one bit.
    function automatic int bm_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_master_if_timeout_counter.sv
// Counts BUSY cycles without ack; expired flags the last permitted cycle so
// the FSM can abandon the transfer without the counter ever wrapping.
module bm_timeout_counter
    import bus_master_if_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = bm_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign expired = (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && !expired) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/bus_master_if.sv
// Turns one MEM-stage load/store into a single bus transfer, stalling the
// pipeline until the responder acks or the timeout expires.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int                    TIMEOUT  = 16,
    parameter logic [WB_DATA_W-1:0]  ERR_DATA = BM_ERR_DATA_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_ce_i,
    input  logic                 cpu_we_i,
    input  logic [WB_ADDR_W-1:0] cpu_addr_i,
    input  logic [WB_DATA_W-1:0] cpu_data_i,
    input  logic                 flush_i,
    output logic [WB_DATA_W-1:0] cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 cpu_err_o,
    output logic [WB_ADDR_W-1:0] bus_addr_o,
    output logic [WB_DATA_W-1:0] bus_data_o,
    input  logic [WB_DATA_W-1:0] bus_data_i,
    output logic                 bus_select_o,
    output logic                 bus_we_o,
    input  logic                 bus_ack_i
);

    bm_state_e            state_reg, state_next;
    logic [WB_ADDR_W-1:0] addr_reg, addr_next;
    logic [WB_DATA_W-1:0] wdata_reg, wdata_next;
    logic                 we_reg, we_next;
    logic [WB_DATA_W-1:0] rdata_reg, rdata_next;
    logic                 err_reg, err_next;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_expired;

    // Clearing outside BUSY guarantees a fresh count on every BUSY entry.
    assign cnt_clear  = (state_reg != BM_BUSY);
    assign cnt_enable = (state_reg == BM_BUSY) && !bus_ack_i;

    bm_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        we_next    = we_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;

        case (state_reg)
            BM_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    addr_next  = cpu_addr_i;
                    wdata_next = cpu_data_i;
                    we_next    = cpu_we_i;
                    state_next = BM_BUSY;
                end
            end
            BM_BUSY: begin
                // A flush lets the bus cycle finish but throws the result away.
                if (bus_ack_i) begin
                    if (flush_i) begin
                        state_next = BM_IDLE;
                    end else begin
                        rdata_next = we_reg ? '0 : bus_data_i;
                        err_next   = 1'b0;
                        state_next = BM_DONE;
                    end
                end else if (cnt_expired) begin
                    if (flush_i) begin
                        state_next = BM_IDLE;
                    end else begin
                        rdata_next = ERR_DATA;
                        err_next   = 1'b1;
                        state_next = BM_DONE;
                    end
                end
            end
            BM_DONE: begin
                state_next = BM_IDLE;
            end
            default: begin
                state_next = BM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= BM_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            we_reg    <= we_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    assign cpu_stall_o  = ((state_reg == BM_IDLE) && cpu_ce_i && !flush_i)
                        || (state_reg == BM_BUSY);
    assign cpu_data_o   = rdata_reg;
    assign cpu_err_o    = (state_reg == BM_DONE) && err_reg;
    assign bus_addr_o   = addr_reg;
    assign bus_data_o   = wdata_reg;
    assign bus_we_o     = we_reg;
    assign bus_select_o = (state_reg == BM_BUSY);

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if (TIMEOUT=4): a per-cycle vector table for
// reset/stray ack/read/write, plus hand sequences for timeout, flush and reset.
module tb_bus_master_if;

    logic        clk;
    logic        rst;
    logic        cpu_ce, cpu_we, flush;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, cpu_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_select, bus_we, bus_ack;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    bus_master_if #(
        .TIMEOUT  (4),
        .ERR_DATA (ERRD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_ce_i     (cpu_ce),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_data_i   (cpu_wdata),
        .flush_i      (flush),
        .cpu_data_o   (cpu_rdata),
        .cpu_stall_o  (cpu_stall),
        .cpu_err_o    (cpu_err),
        .bus_addr_o   (bus_addr),
        .bus_data_o   (bus_wdata),
        .bus_data_i   (bus_rdata),
        .bus_select_o (bus_select),
        .bus_we_o     (bus_we),
        .bus_ack_i    (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce, we, fl, rn, ack;
        logic [31:0] addr, wdata, bdata;
        logic        stall, sel, bwe, err;
        logic [31:0] baddr, bdout, cdata;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic w, input logic f, input logic r,
                         input logic k, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] bd);
        @(negedge clk);
        cpu_ce = c; cpu_we = w; flush = f; rst = r; bus_ack = k;
        cpu_addr = a; cpu_wdata = wd; bus_rdata = bd;
        #1;
    endtask

    task automatic see(input string name, input logic st, input logic sl,
                       input logic er, input logic [31:0] cd);
        chk({name, ".stall"}, {31'd0, cpu_stall}, {31'd0, st});
        chk({name, ".select"}, {31'd0, bus_select}, {31'd0, sl});
        chk({name, ".err"}, {31'd0, cpu_err}, {31'd0, er});
        chk({name, ".data"}, cpu_rdata, cd);
        $display("cycle %s: stall=%0b sel=%0b err=%0b data=%h", name, cpu_stall, bus_select, cpu_err, cpu_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            ce  we  fl  rn  ack  addr          wdata         bdata         stall sel bwe err baddr        bdout        cdata
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,  32'h0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,32'h0,        32'h0,        32'hFFFF_FFFF,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,  32'h0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,32'h0,        32'h0,        32'hFFFF_FFFF,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,  32'h0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,32'h1000_0000,32'h0,        32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,  32'h0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,32'h1000_0000,32'h0,        32'h0000_3A5C,1'b1,1'b1,1'b0,1'b0,32'h1000_0000,32'h0,  32'h0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b0,32'h1000_0000,32'h0,  32'h3A5C};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b0,32'h1000_0000,32'h0,  32'h3A5C};
        vecs[7]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,32'h9000_0000,32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b0,32'h1000_0000,32'h0,  32'h3A5C};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,32'h2000_0004,32'h0000_00A7,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h1000_0000,32'h0,  32'h3A5C};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,32'h2000_0004,32'h0000_0055,32'h0,        1'b1,1'b1,1'b1,1'b0,32'h2000_0004,32'hA7, 32'h3A5C};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b1,1'b0,32'h2000_0008,32'h0000_0066,32'h0,        1'b1,1'b1,1'b1,1'b0,32'h2000_0004,32'hA7, 32'h3A5C};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b1,1'b0,32'h2000_0004,32'h0000_0077,32'h0,        1'b1,1'b1,1'b1,1'b0,32'h2000_0004,32'hA7, 32'h3A5C};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b1,1'b1,32'h2000_0004,32'h0000_0088,32'hFFFF_FFFF,1'b1,1'b1,1'b1,1'b0,32'h2000_0004,32'hA7, 32'h3A5C};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0,1'b1,1'b0,32'h2000_0004,32'hA7, 32'h0};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,        32'h0,        1'b0,1'b0,1'b1,1'b0,32'h2000_0004,32'hA7, 32'h0};

        rst = 1'b0; cpu_ce = 1'b0; cpu_we = 1'b0; flush = 1'b0; bus_ack = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; bus_rdata = '0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].ce, vecs[i].we, vecs[i].fl, vecs[i].rn, vecs[i].ack,
                  vecs[i].addr, vecs[i].wdata, vecs[i].bdata);
            chk($sformatf("row%0d.stall", i), {31'd0, cpu_stall}, {31'd0, vecs[i].stall});
            chk($sformatf("row%0d.select", i), {31'd0, bus_select}, {31'd0, vecs[i].sel});
            chk($sformatf("row%0d.bus_we", i), {31'd0, bus_we}, {31'd0, vecs[i].bwe});
            chk($sformatf("row%0d.err", i), {31'd0, cpu_err}, {31'd0, vecs[i].err});
            chk($sformatf("row%0d.bus_addr", i), bus_addr, vecs[i].baddr);
            chk($sformatf("row%0d.bus_data", i), bus_wdata, vecs[i].bdout);
            chk($sformatf("row%0d.cpu_data", i), cpu_rdata, vecs[i].cdata);
            $display("row %0d: stall=%0b sel=%0b we=%0b err=%0b addr=%h wd=%h rd=%h",
                     i, cpu_stall, bus_select, bus_we, cpu_err, bus_addr, bus_wdata, cpu_rdata);
        end

        // Timeout: four BUSY cycles with no ack, then DONE with ERR_DATA and err.
        drive(1, 0, 0, 1, 0, 32'h3000_0000, 0, 0); see("to_req", 1, 0, 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 1, 0, 32'h3000_0000, 0, 0);
            see($sformatf("to_busy%0d", k), 1, 1, 0, 32'h0);
        end
        drive(0, 0, 0, 1, 0, 0, 0, 0); see("to_done", 0, 0, 1, ERRD);
        drive(0, 0, 0, 1, 0, 0, 0, 0); see("to_after", 0, 0, 0, ERRD);

        // Next read clears err.
        drive(1, 0, 0, 1, 0, 32'h4000_0000, 0, 0);            see("rd2_req", 1, 0, 0, ERRD);
        drive(1, 0, 0, 1, 1, 32'h4000_0000, 0, 32'h1234_5678); see("rd2_busy", 1, 1, 0, ERRD);
        drive(0, 0, 0, 1, 0, 0, 0, 0);                         see("rd2_done", 0, 0, 0, 32'h1234_5678);

        // Flush during a delayed ack: select held until ack, no DONE, data kept.
        drive(1, 0, 0, 1, 0, 32'h5000_0000, 0, 0);             see("fl_req", 1, 0, 0, 32'h1234_5678);
        drive(1, 0, 1, 1, 0, 32'h5000_0000, 0, 0);             see("fl_busy0", 1, 1, 0, 32'h1234_5678);
        drive(1, 0, 1, 1, 0, 32'h5000_0000, 0, 0);             see("fl_busy1", 1, 1, 0, 32'h1234_5678);
        drive(1, 0, 1, 1, 1, 32'h5000_0000, 0, 32'hAAAA_5555); see("fl_busy2", 1, 1, 0, 32'h1234_5678);
        drive(1, 0, 0, 1, 0, 32'h5100_0000, 0, 0);             see("fl_idle", 1, 0, 0, 32'h1234_5678);
        drive(1, 0, 0, 1, 1, 32'h5100_0000, 0, 32'h0000_0BAD); see("fl_rd_busy", 1, 1, 0, 32'h1234_5678);
        drive(0, 0, 0, 1, 0, 0, 0, 0);                         see("fl_rd_done", 0, 0, 0, 32'h0000_0BAD);

        // Reset during BUSY, with ack present: back to IDLE with reset values.
        drive(1, 1, 0, 1, 0, 32'h6000_0000, 32'h77, 0);       see("rs_req", 1, 0, 0, 32'h0000_0BAD);
        drive(1, 1, 0, 1, 0, 32'h6000_0000, 32'h77, 0);       see("rs_busy0", 1, 1, 0, 32'h0000_0BAD);
        drive(1, 1, 0, 0, 1, 32'h6000_0000, 32'h77, 32'h99);  see("rs_busy1", 1, 1, 0, 32'h0000_0BAD);
        drive(0, 0, 0, 1, 1, 0, 0, 32'h99);                   see("rs_after", 0, 0, 0, 32'h0);
        chk("rs_after.bus_addr", bus_addr, 32'h0);
        chk("rs_after.bus_data", bus_wdata, 32'h0);
        chk("rs_after.bus_we", {31'd0, bus_we}, 32'h0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);                         see("rs_idle", 0, 0, 0, 32'h0);
        drive(1, 0, 0, 1, 0, 32'h7000_0000, 0, 0);             see("rs_rd_req", 1, 0, 0, 32'h0);
        drive(1, 0, 0, 1, 1, 32'h7000_0000, 0, 32'h00C0_FFEE); see("rs_rd_busy", 1, 1, 0, 32'h0);
        chk("rs_rd_busy.bus_addr", bus_addr, 32'h7000_0000);
        drive(0, 0, 0, 1, 0, 0, 0, 0);                         see("rs_rd_done", 0, 0, 0, 32'h00C0_FFEE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
